// File: rtl/bru_pkg.sv
// Shared encodings for the EX-stage branch resolution unit: branch opcodes,
// squash-window state and the default PC increment.
package bru_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_J    = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } bru_state_e;

  localparam int unsigned BRU_PC_INC = 1;

endpackage

// File: rtl/branch_resolve_ex_if.sv
// EX-stage branch bus: pipeline controls and operands in, EX/MEM results out.
interface branch_resolve_ex_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [1:0]        br_op;
  logic [ADDR_W-1:0] post_pc;
  logic [ADDR_W-1:0] imm_off;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              valid_out;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              squash;

  modport master (
    output stall, flush, valid_in, br_op, post_pc, imm_off, rs_val, rt_val,
    input  valid_out, taken, target, squash
  );

  modport slave (
    input  stall, flush, valid_in, br_op, post_pc, imm_off, rs_val, rt_val,
    output valid_out, taken, target, squash
  );
endinterface

// File: rtl/bru_squash_ctr.sv
// Counted squash window: opens on a taken branch and stays high for
// SQUASH_CYC unstalled cycles; flush and reset close it at once.
module bru_squash_ctr
  import bru_pkg::*;
#(
  parameter int unsigned SQUASH_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stall,
  input  logic flush,
  output logic squash
);

  bru_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_SQUASH;
            cnt_nxt   = 4'(SQUASH_CYC);
          end
        end
        ST_SQUASH: begin
          // The slot that decrements from 1 is the last killed one.
          if (cnt == 4'd1) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign squash = (state == ST_SQUASH);

endmodule

// File: rtl/branch_resolve_ex.sv
// EX-stage branch resolution: target adder, condition compare, EX/MEM
// registers and squash window. Define BRU_JUMP_EN to resolve br_op=J here.
module branch_resolve_ex
  import bru_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int unsigned PC_INC     = BRU_PC_INC,
  parameter int unsigned SQUASH_CYC = 2,
  parameter int          JIDX_W     = 26
) (
  input logic                clk,
  input logic                reset,
  branch_resolve_ex_if.slave bus
);

  if (SQUASH_CYC < 1 || SQUASH_CYC > 15) begin : g_bad_squash_cyc
    $error("SQUASH_CYC must be within 1..15");
  end
  if (JIDX_W < 1 || JIDX_W >= ADDR_W) begin : g_bad_jidx_w
    $error("JIDX_W must be within 1..ADDR_W-1");
  end

  // Wraps modulo 2^ADDR_W; a negative offset is already sign-extended.
  function automatic logic [ADDR_W-1:0] calc_target(
    input logic        [ADDR_W-1:0] pc,
    input logic signed [ADDR_W-1:0] off
  );
    return pc + off - ADDR_W'(PC_INC);
  endfunction

  logic              squash;
  logic              capture;
  logic              cond;
  logic              start;
  logic [ADDR_W-1:0] target_nxt;

  logic              vld_p1;
  logic              taken_p1;
  logic [ADDR_W-1:0] target_p1;

  assign capture = bus.valid_in & ~bus.stall & ~squash;

  always_comb begin
    cond       = 1'b0;
    target_nxt = calc_target(bus.post_pc, bus.imm_off);
    case (bus.br_op)
      BR_BEQ: cond = (bus.rs_val == bus.rt_val);
      BR_BNE: cond = (bus.rs_val != bus.rt_val);
`ifdef BRU_JUMP_EN
      BR_J: begin
        cond       = 1'b1;
        target_nxt = {bus.post_pc[ADDR_W-1:JIDX_W], bus.imm_off[JIDX_W-1:0]};
      end
`endif
      default: cond = 1'b0;
    endcase
  end

  assign start = capture & cond & ~bus.flush;

  // EX -> EX/MEM boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1   <= capture;
      taken_p1 <= capture & cond;
      if (capture) target_p1 <= target_nxt;
    end
  end

  bru_squash_ctr #(
    .SQUASH_CYC(SQUASH_CYC)
  ) u_squash_ctr (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stall (bus.stall),
    .flush (bus.flush),
    .squash(squash)
  );

  assign bus.valid_out = vld_p1;
  assign bus.taken     = taken_p1;
  assign bus.target    = target_p1;
  assign bus.squash    = squash;

endmodule

// File: tb/tb_branch_resolve_ex.sv
// Directed bench for branch_resolve_ex: vector table plus hand-written
// stall, flush and asynchronous-reset sequences. Honours BRU_JUMP_EN.
module tb_branch_resolve_ex;
  import bru_pkg::*;

`ifdef BRU_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_ex_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  branch_resolve_ex #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .PC_INC    (1),
    .SQUASH_CYC(2),
    .JIDX_W    (26)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        vin;
    logic [1:0]  op;
    logic [31:0] pc;
    logic [31:0] off;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        e_vld;
    logic        e_tk;
    logic        e_sq;
    logic        chk_tgt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt [15];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic set_in(input logic vin, input logic [1:0] op, input logic [31:0] pc,
                        input logic [31:0] off, input logic [31:0] rs, input logic [31:0] rt);
    bus.valid_in = vin;
    bus.br_op    = op;
    bus.post_pc  = pc;
    bus.imm_off  = off;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic t, input logic s);
    check({tag, ".valid_out"}, 32'(bus.valid_out), 32'(v));
    check({tag, ".taken"},     32'(bus.taken),     32'(t));
    check({tag, ".squash"},    32'(bus.squash),    32'(s));
  endtask

  initial begin
    vt[0]  = '{1'b1, BR_BEQ,  32'h10,       32'h4,        32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13};
    vt[1]  = '{1'b1, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{1'b1, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, BR_BNE,  32'h30,       32'h8,        32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{1'b1, BR_BEQ,  32'h1,        32'hFFFFFFFE, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE};
    vt[6]  = '{1'b1, BR_BEQ,  32'h40,       32'h0,        32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[7]  = '{1'b1, BR_BEQ,  32'h50,       32'h0,        32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b1, BR_BNE,  32'h20,       32'hFFFFFFF0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0F};
    vt[9]  = '{1'b0, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[10] = '{1'b0, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b1, BR_J,    32'hF0000005, 32'h123,      32'd0, 32'd0, 1'b1, JEN,  JEN,  JEN,  32'hF0000123};
    vt[12] = '{1'b0, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, JEN,  1'b0, 32'h0};
    vt[13] = '{1'b0, BR_NONE, 32'h0,        32'h0,        32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[14] = '{1'b1, BR_BEQ,  32'h60,       32'h2,        32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 1'b0);
    check("reset.target", bus.target, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      set_in(vt[i].vin, vt[i].op, vt[i].pc, vt[i].off, vt[i].rs, vt[i].rt);
      tick();
      check_out($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_tk, vt[i].e_sq);
      if (vt[i].chk_tgt) check($sformatf("vec%0d.target", i), bus.target, vt[i].e_tgt);
    end
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    tick();

    // One stall cycle right after a taken branch stretches taken and squash.
    set_in(1'b1, BR_BEQ, 32'h100, 32'h8, 32'd9, 32'd9);
    tick();
    check_out("stall.cap", 1'b1, 1'b1, 1'b1);
    check("stall.target", bus.target, 32'h107);
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    bus.stall = 1'b1;
    tick();
    check_out("stall.hold", 1'b1, 1'b1, 1'b1);
    bus.stall = 1'b0;
    tick();
    check_out("stall.sq2", 1'b0, 1'b0, 1'b1);
    tick();
    check_out("stall.end", 1'b0, 1'b0, 1'b0);

    // Flush coinciding with a taken capture wins.
    set_in(1'b1, BR_BEQ, 32'h200, 32'h4, 32'd1, 32'd1);
    bus.flush = 1'b1;
    tick();
    check_out("flushcap", 1'b0, 1'b0, 1'b0);
    check("flushcap.target", bus.target, 32'h107);
    bus.flush = 1'b0;
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    tick();
    check_out("flushcap.after", 1'b0, 1'b0, 1'b0);

    // Flush inside an open window closes it on the next edge.
    set_in(1'b1, BR_BNE, 32'h300, 32'h10, 32'd1, 32'd0);
    tick();
    check_out("flushwin.cap", 1'b1, 1'b1, 1'b1);
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    bus.flush = 1'b1;
    tick();
    check_out("flushwin", 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0;

    // Asynchronous reset in the middle of a squash window.
    set_in(1'b1, BR_BEQ, 32'h400, 32'h20, 32'd2, 32'd2);
    tick();
    check_out("rstwin.cap", 1'b1, 1'b1, 1'b1);
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    check_out("rstwin.async", 1'b0, 1'b0, 1'b0);
    check("rstwin.target", bus.target, 32'h0);
    #1;
    reset = 1'b0;
    set_in(1'b1, BR_BNE, 32'h500, 32'h0, 32'd5, 32'd5);
    tick();
    check_out("rstwin.resume", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, BR_NONE, '0, '0, '0, '0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ex.md
# branch_resolve_ex

Parametrised EX-stage branch resolution unit for the pipeline. It computes the branch target from the post-increment PC and the sign-extended, shifted offset, and evaluates the branch condition on the forwarded register operands. It registers target, taken and valid into the EX/MEM boundary, then drives a counted squash window that kills the wrong-path instructions behind a taken branch. It replaces the purely combinational target adder in EX.

## Interface
- ADDR_W, 32: PC/target width
- DATA_W, 32: operand width for condition compare
- PC_INC, 1: amount subtracted from post_pc (PC advances by 1 per instruction, word addressed)
- SQUASH_CYC, 2: wrong-path slots killed after a taken branch (1..15)
- JIDX_W, 26: jump index width (used only with BRU_JUMP_EN)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all state and outputs
- flush  in  1  external kill (exception/later-stage redirect)
- valid_in  in  1  EX holds a real instruction
- br_op  in  2  0 NONE, 1 BEQ, 2 BNE, 3 J
- post_pc  in  ADDR_W  PC of instruction + PC_INC
- imm_off  in  ADDR_W  sign-extended, pre-shifted offset / jump index
- rs_val, rt_val  in  DATA_W  forwarded operands
- valid_out  out  1  registered valid for EX/MEM
- taken  out  1  registered: redirect fetch
- target  out  ADDR_W  registered redirect address
- squash  out  1  kill the instruction currently in IF/ID

## Operation
- Target (BEQ/BNE): post_pc + imm_off − PC_INC, modulo 2^ADDR_W; wrap-around is silent.
- Condition: BEQ taken when rs_val == rt_val. BNE taken when they differ. NONE is never taken.
- Capture condition: valid_in & ~stall & state IDLE.
- States: IDLE and SQUASH, with a 4-bit down-counter cnt.
- IDLE→SQUASH on capturing a taken branch; cnt loads SQUASH_CYC.
- In SQUASH, cnt decrements each unstalled cycle. SQUASH→IDLE when cnt reaches 1 and decrements.
- Instructions presented during SQUASH are dropped: valid_out=0 and taken=0 for them.
- Priority: reset > flush > stall > normal.
- Flush: next edge clears valid_out and taken, forces IDLE and clears cnt. target keeps its old value.
- Stall: every register holds, including cnt; squash holds its level.
- Reset values: valid_out=0, taken=0, target=0, squash=0, state IDLE, cnt=0.
- Reset mid-squash aborts the window immediately (asynchronous).

## Timing
- Latency is one cycle: inputs sampled at edge N appear on valid_out/taken/target after edge N.
- squash = (state==SQUASH). For a taken branch captured at edge N, squash is high for exactly SQUASH_CYC unstalled cycles starting after edge N.
- A taken pulse lasts one unstalled cycle; a stall stretches it.
- A flush in the same cycle as a taken capture wins: no taken, no squash.
- A back-to-back branch arriving in the squash window is dropped and never re-opens the window.

## Configuration
- BRU_JUMP_EN defined: br_op=3 is taken unconditionally. Its target is {post_pc[ADDR_W-1:JIDX_W], imm_off[JIDX_W-1:0]}, and it opens a squash window like any taken branch.
- BRU_JUMP_EN undefined: br_op=3 behaves as NONE, JIDX_W is unused, and jumps are resolved in ID.

## Structure
- bru_pkg: br_op encoding constants (BR_NONE, BR_BEQ, BR_BNE, BR_J), state encoding, and the default PC_INC.
- Sub-module bru_squash_ctr: holds the state, cnt and squash output. Its inputs are clk, reset, start, stall and flush.
- Target adder and comparator stay inline.

## Test plan
- Reset mid-operation: assert reset during SQUASH → all outputs 0 immediately; resume after release.
- BEQ taken: post_pc=0x10, imm_off=0x4, rs=rt=7 → next cycle valid_out=1, taken=1, target=0x13. squash high for 2 cycles; the two following valid_in are dropped.
- BNE not taken: rs=rt=5 → taken=0, squash stays 0, and the next instruction passes with valid_out=1.
- Wrap and negative offset: post_pc=0x1, imm_off=0xFFFFFFFE, BEQ taken → target=0xFFFFFFFE. post_pc=0x20, imm_off=0xFFFFFFF0 → target=0x0F.
- Stall in window: 1-cycle stall after a taken branch → squash lasts 3 cycles total and taken is held 2 cycles.
- Flush together with a taken BEQ → valid_out=0, taken=0, squash never asserts. With BRU_JUMP_EN, J with post_pc=0xF0000005 and imm_off=0x123 → target=0xF0000123.
